// File: rtl/pcie_tx_vc0_arbiter.sv
// rtl/pcie_tx_vc0_arbiter.sv - credit-gated round-robin arbiter sharing the x1 PCIe core VC0 TX port
module pcie_tx_vc0_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int REQ_TIMEOUT = 1023
) (
    input  logic                    sys_clk_125,
    input  logic                    rst,
    input  logic                    dl_up,
    input  logic [NUM_REQ-1:0]      src_req,
    input  logic [2*NUM_REQ-1:0]    src_type,
    input  logic [11*NUM_REQ-1:0]   src_dcr,
    input  logic [16*NUM_REQ-1:0]   src_data,
    input  logic [NUM_REQ-1:0]      src_st,
    input  logic [NUM_REQ-1:0]      src_end,
    input  logic [NUM_REQ-1:0]      src_nlfy,
    output logic [NUM_REQ-1:0]      src_grant,
    input  logic [8:0]              tx_ca_ph_vc0,
    input  logic [8:0]              tx_ca_nph_vc0,
    input  logic [8:0]              tx_ca_cplh_vc0,
    input  logic [12:0]             tx_ca_pd_vc0,
    input  logic [12:0]             tx_ca_npd_vc0,
    input  logic [12:0]             tx_ca_cpld_vc0,
    input  logic                    tx_rdy_vc0,
    output logic                    tx_req_vc0,
    output logic [15:0]             tx_data_vc0,
    output logic                    tx_st_vc0,
    output logic                    tx_end_vc0,
    output logic                    tx_nlfy_vc0,
    output logic                    req_timeout
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      winner_q, winner_d;
    logic               tx_req_q, tx_req_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] eligible;
    logic [1:0]         cur_type;
    logic [10:0]        cur_dcr;
    logic               hdr_ok, dat_ok;

    // Header credits compare on [7:0], data on [11:0]; the top bit of each pool means infinite.
    always_comb begin
        eligible = '0;
        cur_type = 2'b00;
        cur_dcr  = '0;
        hdr_ok   = 1'b0;
        dat_ok   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_type = src_type[2*i +: 2];
            cur_dcr  = src_dcr[11*i +: 11];
            case (cur_type)
                2'b00: begin
                    hdr_ok = tx_ca_ph_vc0[8] || (tx_ca_ph_vc0[7:0] != 8'd0);
                    dat_ok = tx_ca_pd_vc0[12] || (tx_ca_pd_vc0[11:0] >= {1'b0, cur_dcr});
                end
                2'b01: begin
                    hdr_ok = tx_ca_nph_vc0[8] || (tx_ca_nph_vc0[7:0] != 8'd0);
                    dat_ok = tx_ca_npd_vc0[12] || (tx_ca_npd_vc0[11:0] >= {1'b0, cur_dcr});
                end
                2'b10: begin
                    hdr_ok = tx_ca_cplh_vc0[8] || (tx_ca_cplh_vc0[7:0] != 8'd0);
                    dat_ok = tx_ca_cpld_vc0[12] || (tx_ca_cpld_vc0[11:0] >= {1'b0, cur_dcr});
                end
                default: begin
                    hdr_ok = 1'b0;
                    dat_ok = 1'b0;
                end
            endcase
            eligible[i] = src_req[i] && hdr_ok && dat_ok;
        end
    end

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] scan_idx;
    int            scan_pos;

    // First eligible requester at or after rr_ptr, wrapping to 0.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_pos = 0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos = int'(rr_ptr_q) + k;
            if (scan_pos >= NUM_REQ) begin
                scan_pos = scan_pos - NUM_REQ;
            end
            scan_idx = PW'(scan_pos);
            if (!found && eligible[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    logic [15:0] win_data;
    logic        win_st, win_end, win_nlfy;

    always_comb begin
        win_data = '0;
        win_st   = 1'b0;
        win_end  = 1'b0;
        win_nlfy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_q == PW'(i)) begin
                win_data = src_data[16*i +: 16];
                win_st   = src_st[i];
                win_end  = src_end[i];
                win_nlfy = src_nlfy[i];
            end
        end
    end

    logic pass_en;
    assign pass_en = (state_q == ST_XFER) && (|grant_q);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        winner_d  = winner_q;
        tx_req_d  = tx_req_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dl_up && found) begin
                    winner_d = pick;
                    tx_req_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // Core readiness beats both link-down abort and timeout in the same cycle.
                if (tx_rdy_vc0) begin
                    tx_req_d = 1'b0;
                    grant_d  = NUM_REQ'(1) << winner_q;
                    cnt_d    = '0;
                    state_d  = ST_XFER;
                end else if (!dl_up) begin
                    tx_req_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CW'(REQ_TIMEOUT - 1)) begin
                    tx_req_d  = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (win_end) begin
                    grant_d  = '0;
                    rr_ptr_d = (winner_q == PW'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                grant_d  = '0;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_125 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            winner_q  <= '0;
            tx_req_q  <= 1'b0;
            grant_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            winner_q  <= winner_d;
            tx_req_q  <= tx_req_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign src_grant   = grant_q;
    assign tx_req_vc0  = tx_req_q;
    assign req_timeout = timeout_q;
    assign tx_data_vc0 = pass_en ? win_data : 16'h0000;
    assign tx_st_vc0   = pass_en & win_st;
    assign tx_end_vc0  = pass_en & win_end;
    assign tx_nlfy_vc0 = pass_en & win_nlfy;

endmodule

// File: tb/tb_pcie_tx_vc0_arbiter.sv
// tb/tb_pcie_tx_vc0_arbiter.sv - directed bench with grant/data scoreboard for pcie_tx_vc0_arbiter
module tb_pcie_tx_vc0_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl_up;
    logic [2:0]  src_req;
    logic [5:0]  src_type;
    logic [32:0] src_dcr;
    logic [47:0] src_data;
    logic [2:0]  src_st, src_end, src_nlfy;
    logic [2:0]  src_grant;
    logic [8:0]  ph, nph, cplh;
    logic [12:0] pd, npd, cpld;
    logic        tx_rdy_vc0;
    logic        tx_req_vc0;
    logic [15:0] tx_data_vc0;
    logic        tx_st_vc0, tx_end_vc0, tx_nlfy_vc0;
    logic        req_timeout;

    int errors = 0;
    int checks = 0;
    int n;
    int g;
    int exp_grant_q[$];
    logic [15:0] exp_data_q[$];

    always #4 clk = ~clk;

    pcie_tx_vc0_arbiter #(.NUM_REQ(3), .REQ_TIMEOUT(15)) dut (
        .sys_clk_125(clk), .rst(rst), .dl_up(dl_up),
        .src_req(src_req), .src_type(src_type), .src_dcr(src_dcr), .src_data(src_data),
        .src_st(src_st), .src_end(src_end), .src_nlfy(src_nlfy), .src_grant(src_grant),
        .tx_ca_ph_vc0(ph), .tx_ca_nph_vc0(nph), .tx_ca_cplh_vc0(cplh),
        .tx_ca_pd_vc0(pd), .tx_ca_npd_vc0(npd), .tx_ca_cpld_vc0(cpld),
        .tx_rdy_vc0(tx_rdy_vc0), .tx_req_vc0(tx_req_vc0), .tx_data_vc0(tx_data_vc0),
        .tx_st_vc0(tx_st_vc0), .tx_end_vc0(tx_end_vc0), .tx_nlfy_vc0(tx_nlfy_vc0),
        .req_timeout(req_timeout)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        src_req = '0; src_st = '0; src_end = '0; src_nlfy = '0; src_data = '0;
        tx_rdy_vc0 = 1'b0; dl_up = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx_req", tx_req_vc0, 0);
        chk("rst_grant", src_grant, 0);
        chk("rst_data", tx_data_vc0, 0);
        chk("rst_markers", {tx_st_vc0, tx_end_vc0, tx_nlfy_vc0}, 0);
        chk("rst_timeout", req_timeout, 0);
        rst = 1'b0;
    endtask

    task automatic wait_req(input int rdy_after, output int cycles);
        int c;
        cycles = 0;
        c = 0;
        while (!tx_req_vc0 && c < 64) begin
            @(negedge clk);
            c++;
        end
        if (!tx_req_vc0) begin
            chk("tx_req_seen", tx_req_vc0, 1);
            return;
        end
        while (tx_req_vc0 && cycles < 200) begin
            cycles++;
            chk("no_grant_during_req", src_grant, 0);
            if (cycles == rdy_after) tx_rdy_vc0 = 1'b1;
            @(negedge clk);
        end
        tx_rdy_vc0 = 1'b0;
    endtask

    task automatic xfer(input int nwords, input bit drop, input bit nlfy);
        int gi;
        logic [15:0] w16;
        logic [15:0] e16;
        if (exp_grant_q.size() == 0) begin
            chk("grant_unexpected", src_grant, 0);
            return;
        end
        gi = exp_grant_q.pop_front();
        chk("grant_onehot", src_grant, 48'(1) << gi);
        if (drop) src_req[gi] = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            src_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            src_st   = 3'($urandom);
            src_end  = 3'($urandom);
            src_nlfy = 3'($urandom);
            w16 = 16'($urandom);
            src_data[gi*16 +: 16] = w16;
            src_st[gi]   = (w == 0);
            src_end[gi]  = (w == nwords - 1);
            src_nlfy[gi] = (w == nwords - 1) && nlfy;
            exp_data_q.push_back(w16);
            #1;
            e16 = exp_data_q.pop_front();
            chk("tx_data", tx_data_vc0, e16);
            chk("tx_st", tx_st_vc0, (w == 0));
            chk("tx_end", tx_end_vc0, (w == nwords - 1));
            chk("tx_nlfy", tx_nlfy_vc0, (w == nwords - 1) && nlfy);
            @(negedge clk);
        end
        src_st = '0; src_end = '0; src_nlfy = '0;
        #1;
        chk("grant_drop", src_grant, 0);
        chk("idle_data", tx_data_vc0, 0);
    endtask

    initial begin
        src_type = '0; src_dcr = '0;
        ph = 9'h100; nph = 9'h100; cplh = 9'h100;
        pd = 13'h1000; npd = 13'h1000; cpld = 13'h1000;
        do_reset();

        // 1: single posted request, rdy after 3 request cycles, 4-word TLP
        ph = 9'd8; pd = 13'd8;
        src_type[1:0] = 2'b00; src_dcr[10:0] = 11'd1;
        src_req[0] = 1'b1;
        exp_grant_q.push_back(0);
        wait_req(3, n);
        chk("t1_req_cycles", n, 3);
        xfer(4, 1'b1, 1'b0);

        // 2: all requesting continuously with infinite credits
        do_reset();
        ph = 9'h100; pd = 13'h1000;
        src_type = '0; src_dcr = '0;
        src_req = 3'b111;
        for (int k = 0; k < 6; k++) exp_grant_q.push_back(k % 3);
        for (int k = 0; k < 6; k++) begin
            wait_req(1, n);
            chk("t2_req_cycles", n, 1);
            xfer(2, 1'b0, (k % 3) == 2);
        end
        src_req = '0;
        @(negedge clk);

        // 3: NP blocked on data credit, CPL goes first
        do_reset();
        ph = 9'd0; pd = 13'd0; nph = 9'd8; npd = 13'd0; cplh = 9'd4; cpld = 13'd4;
        src_type = {2'b10, 2'b01, 2'b00};
        src_dcr  = {11'd1, 11'd2, 11'd0};
        src_req  = 3'b110;
        exp_grant_q.push_back(2);
        wait_req(2, n);
        xfer(3, 1'b1, 1'b1);
        npd = 13'd1;
        repeat (8) @(negedge clk);
        chk("t3_np_blocked_req", tx_req_vc0, 0);
        chk("t3_np_blocked_grant", src_grant, 0);
        npd = 13'd2;
        exp_grant_q.push_back(1);
        wait_req(2, n);
        chk("t3_np_req_cycles", n, 2);
        xfer(2, 1'b1, 1'b0);

        // 4: tx_rdy never comes
        do_reset();
        ph = 9'h100; pd = 13'h1000; src_type = '0; src_dcr = '0;
        src_req = 3'b001;
        wait_req(0, n);
        chk("t4_req_cycles", n, 15);
        chk("t4_timeout_pulse", req_timeout, 1);
        src_req = '0;
        @(negedge clk);
        chk("t4_timeout_single", req_timeout, 0);
        chk("t4_idle_req", tx_req_vc0, 0);
        chk("t4_no_grant", src_grant, 0);

        // 5: link drops while request pending
        do_reset();
        src_req = 3'b001;
        @(negedge clk);
        chk("t5_req_up", tx_req_vc0, 1);
        @(negedge clk);
        dl_up = 1'b0;
        @(negedge clk);
        chk("t5_req_dropped", tx_req_vc0, 0);
        chk("t5_no_timeout", req_timeout, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_held_off", {tx_req_vc0, req_timeout, src_grant}, 0);
        end
        src_req = '0; dl_up = 1'b1;
        @(negedge clk);

        // 6: reset in the middle of a transfer restores rr_ptr
        do_reset();
        src_req = 3'b001;
        exp_grant_q.push_back(0);
        wait_req(1, n);
        xfer(2, 1'b1, 1'b0);
        src_req = 3'b010;
        exp_grant_q.push_back(1);
        wait_req(1, n);
        g = exp_grant_q.pop_front();
        chk("t6_grant1", src_grant, 48'(1) << g);
        src_data[g*16 +: 16] = 16'hBEEF;
        src_st[g] = 1'b1;
        #1;
        chk("t6_st_before_rst", tx_st_vc0, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_grant", src_grant, 0);
        chk("t6_rst_markers", {tx_req_vc0, tx_st_vc0, tx_end_vc0}, 0);
        chk("t6_rst_data", tx_data_vc0, 0);
        src_st = '0;
        src_req = 3'b011;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_grant_q.push_back(0);
        wait_req(1, n);
        xfer(2, 1'b1, 1'b0);
        src_req = '0;
        @(negedge clk);

        chk("scoreboard_empty", 48'(exp_grant_q.size() + exp_data_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
